// File: rtl/seg8_scan_driver.sv
// seg8_scan_driver
//   Double-buffered, time-multiplexed driver for eight common-cathode
//   seven-segment digits. New data is captured into a pending buffer and
//   only promoted to the displayed (active) buffer on a frame boundary, so
//   the display never tears. Each digit slot begins with a blanking gap.
//
// Ports
//   CP              clock, rising edge
//   CR_n            asynchronous active-low reset
//   load            one-cycle strobe capturing din/dig_en/dp_en
//   din[31:0]       digit i = din[4i+3:4i], hex value
//   dig_en[7:0]     bit i lights digit i
//   dp_en[7:0]      bit i lights the decimal point of digit i
//   seg_cs_pin      active-high one-hot digit select
//   seg_data_0_pin  active-high segments, bit0 = a .. bit6 = g, bit7 = dp
//   frame_done      one-cycle pulse after the slot index wraps 7 -> 0
//   pending         pending buffer holds data not yet shown
module seg8_scan_driver #(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        CP,
  input  logic        CR_n,
  input  logic        load,
  input  logic [31:0] din,
  input  logic [7:0]  dig_en,
  input  logic [7:0]  dp_en,
  output logic [7:0]  seg_cs_pin,
  output logic [7:0]  seg_data_0_pin,
  output logic        frame_done,
  output logic        pending
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [PW:0]   BLANK_W  = (PW + 1)'(BLANK_CYC);

  logic [PW-1:0] pre_q, pre_d;
  logic [2:0]    k_q, k_d;
  logic [31:0]   a_din_q, a_din_d, p_din_q, p_din_d;
  logic [7:0]    a_en_q, a_en_d, p_en_q, p_en_d;
  logic [7:0]    a_dp_q, a_dp_d, p_dp_q, p_dp_d;
  logic          pend_q, pend_d;
  logic [7:0]    cs_q, cs_d;
  logic [7:0]    seg_q, seg_d;
  logic          fd_q, fd_d;
  logic          boundary;
  logic          lit;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_to_seg = 7'h3F;
      4'h1: hex_to_seg = 7'h06;
      4'h2: hex_to_seg = 7'h5B;
      4'h3: hex_to_seg = 7'h4F;
      4'h4: hex_to_seg = 7'h66;
      4'h5: hex_to_seg = 7'h6D;
      4'h6: hex_to_seg = 7'h7D;
      4'h7: hex_to_seg = 7'h07;
      4'h8: hex_to_seg = 7'h7F;
      4'h9: hex_to_seg = 7'h6F;
      4'hA: hex_to_seg = 7'h77;
      4'hB: hex_to_seg = 7'h7C;
      4'hC: hex_to_seg = 7'h39;
      4'hD: hex_to_seg = 7'h5E;
      4'hE: hex_to_seg = 7'h79;
      default: hex_to_seg = 7'h71;
    endcase
  endfunction

  always_comb begin
    pre_d   = pre_q + PW'(1);
    k_d     = k_q;
    a_din_d = a_din_q;
    a_en_d  = a_en_q;
    a_dp_d  = a_dp_q;
    p_din_d = p_din_q;
    p_en_d  = p_en_q;
    p_dp_d  = p_dp_q;
    pend_d  = pend_q;

    if (pre_q == PRE_LAST) begin
      pre_d = '0;
      k_d   = k_q + 3'd1;
    end

    boundary = (pre_q == PRE_LAST) && (k_q == 3'd7);

    if (load) begin
      p_din_d = din;
      p_en_d  = dig_en;
      p_dp_d  = dp_en;
      pend_d  = 1'b1;
    end

    // A load landing on the boundary bypasses the pending buffer entirely.
    if (boundary) begin
      if (load) begin
        a_din_d = din;
        a_en_d  = dig_en;
        a_dp_d  = dp_en;
        pend_d  = 1'b0;
      end else if (pend_q) begin
        a_din_d = p_din_q;
        a_en_d  = p_en_q;
        a_dp_d  = p_dp_q;
        pend_d  = 1'b0;
      end
    end

    // pre >= BLANK_CYC written as pre+1 > BLANK_CYC so BLANK_CYC = 0 stays a
    // plain compare rather than a constant-true one.
    lit   = (({1'b0, pre_q} + (PW + 1)'(1)) > BLANK_W) && a_en_q[k_q];
    cs_d  = lit ? (8'b1 << k_q) : '0;
    seg_d = lit ? {a_dp_q[k_q], hex_to_seg(a_din_q[{k_q, 2'b00} +: 4])} : '0;
    fd_d  = boundary;
  end

  always_ff @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      pre_q   <= '0;
      k_q     <= '0;
      a_din_q <= '0;
      a_en_q  <= '0;
      a_dp_q  <= '0;
      p_din_q <= '0;
      p_en_q  <= '0;
      p_dp_q  <= '0;
      pend_q  <= 1'b0;
      cs_q    <= '0;
      seg_q   <= '0;
      fd_q    <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      k_q     <= k_d;
      a_din_q <= a_din_d;
      a_en_q  <= a_en_d;
      a_dp_q  <= a_dp_d;
      p_din_q <= p_din_d;
      p_en_q  <= p_en_d;
      p_dp_q  <= p_dp_d;
      pend_q  <= pend_d;
      cs_q    <= cs_d;
      seg_q   <= seg_d;
      fd_q    <= fd_d;
    end
  end

  assign seg_cs_pin     = cs_q;
  assign seg_data_0_pin = seg_q;
  assign frame_done     = fd_q;
  assign pending        = pend_q;

endmodule

// File: tb/tb_seg8_scan_driver.sv
module tb_seg8_scan_driver;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 8 * DIV;

  logic        CP = 1'b0;
  logic        CR_n = 1'b1;
  logic        load = 1'b0;
  logic [31:0] din = '0;
  logic [7:0]  dig_en = '0;
  logic [7:0]  dp_en = '0;

  logic [7:0] cs, seg, cs2, seg2;
  logic       fd, pend, fd2, pend2;

  int total = 0;
  int bad = 0;

  seg8_scan_driver #(.SCAN_DIV(DIV), .BLANK_CYC(BLANK)) dut (
    .CP(CP), .CR_n(CR_n), .load(load), .din(din), .dig_en(dig_en), .dp_en(dp_en),
    .seg_cs_pin(cs), .seg_data_0_pin(seg), .frame_done(fd), .pending(pend)
  );

  seg8_scan_driver #(.SCAN_DIV(2), .BLANK_CYC(0)) dut2 (
    .CP(CP), .CR_n(CR_n), .load(load), .din(din), .dig_en(dig_en), .dp_en(dp_en),
    .seg_cs_pin(cs2), .seg_data_0_pin(seg2), .frame_done(fd2), .pending(pend2)
  );

  always #5 CP = ~CP;

  logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position in the frame is a plain cycle count; slot and
  // phase fall out of division.
  int unsigned m_cyc = 0;
  logic [31:0] m_adin = '0, m_pdin = '0;
  logic [7:0]  m_aen = '0, m_adp = '0, m_pen = '0, m_pdp = '0;
  bit          m_pf = 1'b0;
  logic [7:0]  e_cs = '0, e_seg = '0;
  logic        e_fd = 1'b0;
  int          m_slot, m_phase;
  bit          m_last;

  always @(posedge CP or negedge CR_n) begin
    if (!CR_n) begin
      m_cyc <= 0; m_adin <= '0; m_aen <= '0; m_adp <= '0;
      m_pdin <= '0; m_pen <= '0; m_pdp <= '0; m_pf <= 1'b0;
      e_cs <= '0; e_seg <= '0; e_fd <= 1'b0;
    end else begin
      m_phase = int'(m_cyc % DIV);
      m_slot  = int'(m_cyc / DIV);
      m_last  = (m_cyc == FRAME - 1);
      if (m_phase >= BLANK && m_aen[m_slot]) begin
        e_cs  <= 8'(1 << m_slot);
        e_seg <= {m_adp[m_slot], SEG_TAB[m_adin[4*m_slot +: 4]]};
      end else begin
        e_cs  <= '0;
        e_seg <= '0;
      end
      e_fd <= m_last;
      if (m_last && load) begin
        m_adin <= din; m_aen <= dig_en; m_adp <= dp_en; m_pf <= 1'b0;
      end else if (m_last && m_pf) begin
        m_adin <= m_pdin; m_aen <= m_pen; m_adp <= m_pdp; m_pf <= 1'b0;
      end else if (load) begin
        m_pdin <= din; m_pen <= dig_en; m_pdp <= dp_en; m_pf <= 1'b1;
      end
      m_cyc <= m_last ? 0 : m_cyc + 1;
    end
  end

  task automatic tick();
    @(posedge CP);
    #1;
  endtask

  task automatic wait_fd(input int budget, input bit second, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if ((second ? fd2 : fd) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    #1 CR_n = 1'b0;
    repeat (5) @(posedge CP);
    #1;
    total++;
    if ({cs, seg, fd, pend} !== 18'h0) begin
      bad++;
      $display("FAIL reset_hold: got cs=%h seg=%h fd=%b pend=%b, expected all 0", cs, seg, fd, pend);
    end
    CR_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      total++;
      if ({cs, seg, pend} !== 17'h0 || fd !== ((i % FRAME) == FRAME - 1)) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: got cs=%h seg=%h fd=%b pend=%b, expected cs=00 seg=00 fd=%b pend=0",
                 i, cs, seg, fd, pend, (i % FRAME) == FRAME - 1);
      end
      if (fd === 1'b1) pulses++;
    end
    total++;
    if (pulses != 3) begin
      bad++;
      $display("FAIL reset_frames: got %0d frame_done pulses, expected 3", pulses);
    end
  endtask

  task automatic test_basic_scan();
    bit ok;
    int n3, nblank, idx;
    logic [7:0] exp_cs;
    din = 32'h76543210; dig_en = 8'hFF; dp_en = 8'h00; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fd(2 * FRAME, 1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL basic_wait: got no frame_done, expected one within %0d cycles", 2 * FRAME); end
    n3 = 0; nblank = 0;
    for (int s = 1; s <= FRAME; s++) begin
      tick();
      idx = s - 1;
      exp_cs = ((idx % DIV) < BLANK) ? 8'h00 : 8'(1 << (idx / DIV));
      total++;
      if (cs !== exp_cs || {cs, seg, fd, pend} !== {e_cs, e_seg, e_fd, m_pf}) begin
        bad++;
        $display("FAIL basic_scan @%0t: got cs=%h seg=%h fd=%b pend=%b, expected cs=%h/%h seg=%h fd=%b pend=%b",
                 $time, cs, seg, fd, pend, exp_cs, e_cs, e_seg, e_fd, m_pf);
      end
      if (cs === 8'h08 && seg === 8'h4F) n3++;
      if (cs === 8'h00) nblank++;
    end
    total++;
    if (n3 != 6 || nblank != 16) begin
      bad++;
      $display("FAIL basic_counts: got slot3 lit=%0d blank=%0d, expected 6 and 16", n3, nblank);
    end
  endtask

  task automatic test_masks();
    bit ok;
    int nd0, nd13;
    din = 32'hFFFFFFFF; dig_en = 8'h0F; dp_en = 8'h81; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fd(2 * FRAME, 1'b0, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL masks_wait: got no frame_done, expected one within %0d cycles", 2 * FRAME); end
    nd0 = 0; nd13 = 0;
    for (int s = 1; s <= FRAME; s++) begin
      tick();
      total++;
      if (cs[7:4] !== 4'h0 || {cs, seg, fd, pend} !== {e_cs, e_seg, e_fd, m_pf}) begin
        bad++;
        $display("FAIL masks @%0t: got cs=%h seg=%h fd=%b pend=%b, expected cs=%h seg=%h fd=%b pend=%b",
                 $time, cs, seg, fd, pend, e_cs, e_seg, e_fd, m_pf);
      end
      if (cs === 8'h01 && seg === 8'hF1) nd0++;
      if ((cs === 8'h02 || cs === 8'h04 || cs === 8'h08) && seg === 8'h71) nd13++;
    end
    total++;
    if (nd0 != 6 || nd13 != 18 || fd !== 1'b1) begin
      bad++;
      $display("FAIL masks_counts: got d0=%0d d1-3=%0d fd_at_64=%b, expected 6 18 1", nd0, nd13, fd);
    end
  endtask

  task automatic test_no_tearing();
    int nlit;
    bit exp_pend;
    dig_en = 8'hFF; dp_en = 8'h00;
    for (int c = 0; c < FRAME; c++) begin
      load = (c == 16 || c == 40);
      din  = (c < 40) ? 32'h11111111 : 32'h22222222;
      tick();
      load = 1'b0;
      exp_pend = (c >= 16 && c < FRAME - 1);
      total++;
      if (pend !== exp_pend || seg === 8'h06 || seg === 8'h5B ||
          {cs, seg, fd, pend} !== {e_cs, e_seg, e_fd, m_pf}) begin
        bad++;
        $display("FAIL tearing_old c=%0d: got cs=%h seg=%h fd=%b pend=%b, expected cs=%h seg=%h fd=%b pend=%b",
                 c, cs, seg, fd, pend, e_cs, e_seg, e_fd, exp_pend);
      end
    end
    nlit = 0;
    for (int s = 1; s <= FRAME; s++) begin
      tick();
      total++;
      if (seg !== ((cs !== 8'h00) ? 8'h5B : 8'h00) || {cs, seg, fd, pend} !== {e_cs, e_seg, e_fd, m_pf}) begin
        bad++;
        $display("FAIL tearing_new @%0t: got cs=%h seg=%h fd=%b pend=%b, expected cs=%h seg=%h fd=%b pend=%b",
                 $time, cs, seg, fd, pend, e_cs, e_seg, e_fd, m_pf);
      end
      if (cs !== 8'h00) nlit++;
    end
    total++;
    if (nlit != 48) begin
      bad++;
      $display("FAIL tearing_lit: got %0d lit cycles, expected 48", nlit);
    end
  endtask

  task automatic test_boundary_load();
    logic [31:0] v;
    logic [7:0]  dpv;
    v = $urandom; dpv = 8'($urandom);
    for (int c = 0; c < FRAME; c++) begin
      load = (c == FRAME - 1);
      din = v; dig_en = 8'hFF; dp_en = dpv;
      tick();
      load = 1'b0;
      total++;
      if (pend !== 1'b0 || {cs, seg, fd, pend} !== {e_cs, e_seg, e_fd, m_pf}) begin
        bad++;
        $display("FAIL bnd_load c=%0d: got cs=%h seg=%h fd=%b pend=%b, expected cs=%h seg=%h fd=%b pend=0",
                 c, cs, seg, fd, pend, e_cs, e_seg, e_fd);
      end
    end
    for (int s = 1; s <= FRAME; s++) begin
      tick();
      total++;
      if (pend !== 1'b0 || (s >= 3 && s <= 8 && seg !== {dpv[0], SEG_TAB[v[3:0]]}) ||
          {cs, seg, fd, pend} !== {e_cs, e_seg, e_fd, m_pf}) begin
        bad++;
        $display("FAIL bnd_show s=%0d: got cs=%h seg=%h pend=%b, expected cs=%h seg=%h pend=0",
                 s, cs, seg, pend, e_cs, e_seg);
      end
    end
  endtask

  task automatic test_reset_mid();
    repeat (32) tick();
    din = $urandom | 32'h1; dig_en = 8'hFF; dp_en = 8'h00; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    total++;
    if (cs !== 8'h10 || pend !== 1'b1) begin
      bad++;
      $display("FAIL rst_mid_pre: got cs=%h pend=%b, expected cs=10 pend=1", cs, pend);
    end
    #2 CR_n = 1'b0;
    #1;
    total++;
    if ({cs, seg, fd, pend} !== 18'h0) begin
      bad++;
      $display("FAIL rst_mid_async: got cs=%h seg=%h fd=%b pend=%b, expected all 0", cs, seg, fd, pend);
    end
    repeat (3) @(posedge CP);
    #1 CR_n = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      total++;
      if ({cs, seg, pend} !== 17'h0 || fd !== ((i % FRAME) == FRAME - 1)) begin
        bad++;
        $display("FAIL rst_mid_after cycle %0d: got cs=%h seg=%h fd=%b pend=%b, expected zeros fd=%b",
                 i, cs, seg, fd, pend, (i % FRAME) == FRAME - 1);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      load = ($urandom_range(0, 7) == 0);
      din = $urandom; dig_en = 8'($urandom); dp_en = 8'($urandom);
      tick();
      total++;
      if ({cs, seg, fd, pend} !== {e_cs, e_seg, e_fd, m_pf}) begin
        bad++;
        $display("FAIL random i=%0d: got cs=%h seg=%h fd=%b pend=%b, expected cs=%h seg=%h fd=%b pend=%b",
                 i, cs, seg, fd, pend, e_cs, e_seg, e_fd, m_pf);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_small_div();
    bit ok;
    logic [31:0] v;
    int slot;
    v = 32'h89ABCDEF;
    #2 CR_n = 1'b0;
    @(posedge CP);
    #1 CR_n = 1'b1;
    din = v; dig_en = 8'hFF; dp_en = 8'h00; load = 1'b1;
    tick();
    load = 1'b0;
    wait_fd(40, 1'b1, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL small_wait: got no frame_done, expected one within 40 cycles"); end
    for (int s = 1; s <= 16; s++) begin
      tick();
      slot = (s - 1) / 2;
      total++;
      if (cs2 !== 8'(1 << slot) || seg2 !== {1'b0, SEG_TAB[v[4*slot +: 4]]}) begin
        bad++;
        $display("FAIL small_div s=%0d: got cs=%h seg=%h, expected cs=%h seg=%h",
                 s, cs2, seg2, 8'(1 << slot), {1'b0, SEG_TAB[v[4*slot +: 4]]});
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before 1 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_scan();
    test_masks();
    test_no_tearing();
    test_boundary_load();
    test_reset_mid();
    test_random();
    test_small_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
